// File: rtl/dct_bfly_sched.sv
// First butterfly stage of an 8-point 1D DCT: gathers 8 samples, forms 4 sums and
// 4 differences on one shared adder, then streams the 8 exact 17-bit results.

module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};
endmodule

module complement16 (
  input  logic [15:0] x,
  input  logic        inv,
  output logic [15:0] y
);
  assign y = x ^ {16{inv}};
endmodule

module dct_bfly_sched #(
  parameter int DATA_W = 16,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              frame_err,
  input  logic              clr_err
);

  if (DATA_W != 16) begin : g_bad_data_w
    $error("dct_bfly_sched: DATA_W must be 16 (fixed by adder16)");
  end
  if (N != 8) begin : g_bad_n
    $error("dct_bfly_sched: N must be 8");
  end

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(N - 1);

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic [15:0] x [8];
  logic [16:0] r [8];

  logic        in_xfer;
  logic [15:0] a_op;
  logic [15:0] b_raw;
  logic [15:0] b_cmp;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        sub_op;

  // Handshake: a beat moves on a rising edge where valid && ready; a source holds
  // valid and its payload until that edge, and ready never waits on valid.
  assign in_xfer = (state == S_LOAD) && in_valid;

  // cnt is shared: beat index in LOAD, op index k in CALC, result index in OUT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_idx   = 3'd0;
    out_last  = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_nxt = cnt + 3'd1;
          if (cnt == LAST_CNT) state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy    = 1'b1;
        cnt_nxt = cnt + 3'd1;
        if (cnt == LAST_CNT) state_nxt = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r[cnt];
        out_idx   = cnt;
        out_last  = (cnt == LAST_CNT);
        if (out_ready) begin
          cnt_nxt = cnt + 3'd1;
          if (cnt == LAST_CNT) state_nxt = S_LOAD;
        end
      end
      default: begin
        state_nxt = S_LOAD;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Op k pairs x[k mod 4] with x[7 - (k mod 4)]; ops 4..7 subtract.
  assign sub_op = cnt[2];
  assign a_op   = x[{1'b0, cnt[1:0]}];
  assign b_raw  = x[{1'b1, ~cnt[1:0]}];

  complement16 u_cmp (
    .x   (b_raw),
    .inv (sub_op),
    .y   (b_cmp)
  );

  adder16 u_add (
    .a    (a_op),
    .b    (b_cmp),
    .cin  (sub_op),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        x[i] <= '0;
        r[i] <= '0;
      end
    end else begin
      if (in_xfer) x[cnt] <= in_data;
      // Bit 16 recovers the true sign: the 17-bit sum of both sign-extended operands.
      if (state == S_CALC) r[cnt] <= {a_op[15] ^ b_cmp[15] ^ add_cout, add_sum};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (in_xfer && (in_last != (cnt == LAST_CNT))) begin
      frame_err <= 1'b1;
    end else if (clr_err) begin
      frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct_bfly_sched.sv
// Bench for dct_bfly_sched: table-driven frames plus hand sequences for backpressure,
// framing errors, mid-frame reset and back-to-back throughput, checked by a scoreboard.

module tb_dct_bfly_sched;

  typedef logic [7:0][15:0] frame_t;
  typedef logic [7:0][16:0] res_t;
  typedef struct {
    frame_t x;
    res_t   r;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        frame_err;
  logic        clr_err = 1'b0;

  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          exp_err = 0;
  int          first_out_cyc = -1;
  int          bp_mode = 0;
  int          stall = 0;
  logic [20:0] exp_q[$];
  vec_t        vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_bfly_sched #(.DATA_W(16), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endfunction

  function automatic void fail(string name);
    total++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endfunction

  function automatic res_t model(frame_t x);
    res_t r;
    logic signed [16:0] a, b;
    for (int k = 0; k < 4; k++) begin
      a = $signed({x[k][15], x[k]});
      b = $signed({x[7-k][15], x[7-k]});
      r[k]   = a + b;
      r[k+4] = a - b;
    end
    return r;
  endfunction

  task automatic push_frame(input res_t r);
    for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), (k == 7) ? 1'b1 : 1'b0, r[k]});
  endtask

  // Drives one frame; checks the sticky error flag after every accepted beat.
  task automatic send_frame(input frame_t xs, input int last_beat, input int clr_beat,
                            output int first_c, output int last_c);
    first_c = -1;
    last_c  = -1;
    for (int i = 0; i < 8; i++) begin
      logic acc;
      int   n;
      in_valid = 1'b1;
      in_data  = xs[i];
      in_last  = (i == last_beat);
      clr_err  = (i == clr_beat);
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) fail($sformatf("in_accept_beat%0d", i));
      if ((i == last_beat) != (i == 7)) exp_err = 1;
      else if (i == clr_beat) exp_err = 0;
      check($sformatf("frame_err_beat%0d", i), 32'(frame_err), 32'(exp_err));
      if (i == 0) first_c = cyc;
      if (i == 7) last_c = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr_err  = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = stall 5 cycles on idx 2.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: begin
          out_ready = 1'($urandom_range(0, 1));
          stall = 0;
        end
        2: begin
          if (out_valid && out_idx == 3'd2 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: begin
          out_ready = 1'b1;
          stall = 0;
        end
      endcase
    end
  end

  // Output monitor: scoreboard pops on each transfer; stalled outputs must hold.
  initial begin
    logic        hold_vld;
    logic [16:0] hold_data;
    logic [2:0]  hold_idx;
    logic [20:0] e;
    hold_vld = 1'b0;
    hold_data = '0;
    hold_idx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(hold_data));
          check("hold_idx", 32'(out_idx), 32'(hold_idx));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            fail("out_unexpected");
          end else begin
            e = exp_q.pop_front();
            check($sformatf("out_idx%0d", e[20:18]), 32'({out_idx, out_last, out_data}), 32'(e));
          end
          if (out_idx == 3'd0) first_out_cyc = cyc + 1;
        end
        hold_vld  = out_valid && !out_ready;
        hold_data = out_data;
        hold_idx  = out_idx;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "timeout");
  end

  initial begin
    frame_t f, f2;
    int     fc, lc, fc1, fc2, fc3;

    for (int i = 0; i < 8; i++) vecs[0].x[i] = 16'(i);
    for (int k = 0; k < 4; k++) vecs[0].r[k] = 17'h00007;
    vecs[0].r[4] = 17'h1FFF9;
    vecs[0].r[5] = 17'h1FFFB;
    vecs[0].r[6] = 17'h1FFFD;
    vecs[0].r[7] = 17'h1FFFF;
    vecs[1].x = '0;
    vecs[1].x[0] = 16'h7FFF;
    vecs[1].x[7] = 16'h7FFF;
    vecs[1].x[1] = 16'h8000;
    vecs[1].x[6] = 16'h7FFF;
    vecs[1].r = '0;
    vecs[1].r[0] = 17'h0FFFE;
    vecs[1].r[1] = 17'h1FFFF;
    vecs[1].r[5] = 17'h10001;
    vecs[2].x = '0;
    vecs[2].r = '0;
    for (int i = 0; i < 8; i++) vecs[3].x[i] = (i < 4) ? 16'h8000 : 16'h7FFF;
    for (int k = 0; k < 4; k++) begin
      vecs[3].r[k]   = 17'h1FFFF;
      vecs[3].r[k+4] = 17'h10001;
    end
    for (int i = 0; i < 8; i++) vecs[4].x[i] = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      vecs[4].r[k]   = 17'h1FFFE;
      vecs[4].r[k+4] = 17'h00000;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    bp_mode = 0;
    for (int v = 0; v < 5; v++) begin
      first_out_cyc = -1;
      push_frame(vecs[v].r);
      send_frame(vecs[v].x, 7, -1, fc, lc);
      wait_drain();
      check($sformatf("latency_vec%0d", v), 32'(first_out_cyc - lc), 32'd9);
    end

    bp_mode = 2;
    for (int i = 0; i < 8; i++) f[i] = 16'($urandom_range(0, 65535));
    push_frame(model(f));
    send_frame(f, 7, -1, fc, lc);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    begin
      int n;
      n = 0;
      while (!(out_valid && out_idx == 3'd7) && n < 100) begin
        check("busy_no_accept", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 100) fail("bp_wait_idx7");
    end
    in_valid = 1'b0;
    in_data  = '0;
    wait_drain();
    check("bp_stall_cycles", 32'(stall), 32'd5);
    bp_mode = 0;

    bp_mode = 1;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 8; i++) f[i] = 16'($urandom_range(0, 65535));
      push_frame(model(f));
      send_frame(f, 7, -1, fc, lc);
    end
    wait_drain();
    bp_mode = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) f[i] = 16'($urandom_range(0, 65535));
    push_frame(model(f));
    send_frame(f, 5, 5, fc, lc);
    wait_drain();
    check("err_sticky", 32'(frame_err), 32'd1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    exp_err = 0;
    check("err_cleared", 32'(frame_err), 32'd0);
    push_frame(vecs[0].r);
    send_frame(vecs[0].x, 7, -1, fc, lc);
    wait_drain();
    check("err_clean_frame", 32'(frame_err), 32'd0);

    for (int i = 0; i < 8; i++) f[i] = 16'h4000 + 16'(i * 1111);
    send_frame(f, 7, -1, fc, lc);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) f2[i] = 16'(7 - i) * 16'h0101;
    push_frame(model(f2));
    send_frame(f2, 7, -1, fc, lc);
    wait_drain();

    for (int i = 0; i < 8; i++) f[i] = 16'($urandom_range(0, 65535));
    push_frame(model(f));
    send_frame(f, 7, -1, fc1, lc);
    push_frame(vecs[1].r);
    send_frame(vecs[1].x, 7, -1, fc2, lc);
    push_frame(model(f2));
    send_frame(f2, 7, -1, fc3, lc);
    wait_drain();
    check("period_1_2", 32'(fc2 - fc1), 32'd24);
    check("period_2_3", 32'(fc3 - fc2), 32'd24);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dct_bfly_sched.md
Name: dct_bfly_sched

Overview:
- Sequencer for the first butterfly stage of the 8-point 1D DCT, used row and column-wise by the 2D DCT.
- Collects 8 signed 16-bit samples, then time-multiplexes one shared adder16 + complement pair to produce 4 sums and 4 differences, one operation per cycle.
- Streams the 8 results to the next DCT stage over a valid/ready handshake.

Parameters:
- DATA_W, 16, sample width. Only 16 is legal (fixed by adder16); any other value is an elaboration error.
- N, 8, points per frame. Only 8 is legal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  16  signed sample x[i], i = beat index 0..7
- in_last  in  1  frame-end marker; expected on beat 7 only
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  17  signed result, exact (no wrap)
- out_idx  out  3  result index 0..7
- out_last  out  1  high with index 7
- busy  out  1  high in CALC or OUT
- frame_err  out  1  sticky in_last protocol error
- clr_err  in  1  synchronous clear of frame_err

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; all counters 0; sample and result registers 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, frame_err=0.
- State LOAD:
  - in_ready=1. A transfer is in_valid&&in_ready; it writes x[cnt] and increments cnt.
  - The transfer at cnt=7 goes to CALC next cycle with cnt=0.
  - in_last does not affect framing.
  - frame_err sets if in_last=1 on beats 0..6, or in_last=0 on beat 7.
- State CALC (exactly 8 cycles, op k=0..7; in_ready=0, out_valid=0):
  - k<4: r[k] = x[k] + x[7-k]. Complement X=0, Cin=0.
  - k>=4: r[k] = x[k-4] - x[11-k]. Complement X=1 inverts B, Cin=1.
  - Adder16 A = x[k or k-4], B = complement output.
  - r[k][15:0] = adder sum.
  - r[k][16] = A[15] ^ B'[15] ^ carry, where B' is the complemented operand. This gives the exact 17-bit sign-extended result.
  - Only one adder16 and one complement instance exist in the block; no other adders.
  - r[k] is registered at the end of cycle k. After k=7, go to OUT.
- State OUT:
  - out_valid=1; out_data=r[ocnt], out_idx=ocnt, out_last=(ocnt==7).
  - While out_valid&&!out_ready, all out_* hold stable.
  - Each transfer increments ocnt. The transfer at ocnt=7 returns to LOAD, and in_ready=1 the next cycle.
- Latency and throughput:
  - Last input accepted at edge T: CALC occupies edges T+1..T+8, out_valid rises after edge T+8, first result transfer possible at edge T+9.
  - Minimum frame period: 8 in + 8 calc + 8 out = 24 cycles. No overlap between frames.
- frame_err: clr_err=1 clears it next edge. A set and a clear in the same cycle resolve to set.
- Reset asserted mid-frame: immediate return to reset values; partial frame discarded.
- in_data is ignored when in_ready=0. out_ready is ignored when out_valid=0.

Test Plan:
- Ramp x=0..7, in_last on beat 7, out_ready=1 -> outputs in order 7,7,7,7, then -7,-5,-3,-1 (0x00007 ×4, then 0x1FFF9, 0x1FFFB, 0x1FFFD, 0x1FFFF); out_last only with idx 7; frame_err=0; first out transfer 9 cycles after the last input edge.
- Extremes x0=x7=0x7FFF, x1=0x8000, x6=0x7FFF, others 0 -> r0=0x0FFFE, r1=0x1FFFF (-1), r4=0x00000, r5=0x10001 (-65535).
- Backpressure: out_ready=0 for 5 cycles while idx 2 is presented -> out_data/out_idx held constant, all 8 results delivered exactly once in order; in_valid held high during this time accepts nothing.
- Protocol: in_last on beat 5 and absent on beat 7 -> frame_err=1 after beat 5, frame still processed normally; clr_err pulse -> frame_err=0 next cycle; a clean following frame leaves it 0.
- Async reset during CALC at k=3 -> out_valid=0, in_ready=1, busy=0 immediately; next full frame produces correct results with no residue from the aborted frame.
- Back-to-back frames with in_valid and out_ready held high -> 24-cycle frame period; in_ready=0 from CALC entry until the cycle after out_last transfers.
